// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared types and constants for the commit-stage exception logic:
//   exc_flags_t  - per-instruction exception flags carried down the pipeline
//   EXC_*        - MIPS ExcCode values (5-bit, zero-extended on the CP0 port)
//   state_t      - commit unit state (normal commit / redirect in progress)
//   BAD_ADDR_*   - source select for the BadVAddr payload
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef struct packed {
        logic if_adel;
        logic ri;
        logic syscall;
        logic brk;
        logic ov;
        logic adel;
        logic ades;
        logic eret;
    } exc_flags_t;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic BAD_ADDR_PC   = 1'b0;
    localparam logic BAD_ADDR_DATA = 1'b1;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// -----------------------------------------------------------------------------
// exc_prio_enc
// Combinational exception priority encoder. Picks the highest-priority cause
// among a pending interrupt and the instruction's exception flags.
// Ports:
//   flags_i          - exc_flags_t as a flat vector
//   int_req_i        - interrupt request (line or latched pending)
//   any_exc_o        - some exception (including interrupt) is present
//   exc_code_o       - ExcCode of the winning cause
//   bad_addr_valid_o - winning cause is an address error (BadVAddr written)
//   bad_addr_sel_o   - BadVAddr source: BAD_ADDR_PC or BAD_ADDR_DATA
// ERET is not an exception and is left to the caller.
// -----------------------------------------------------------------------------
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [7:0] flags_i,
    input  logic       int_req_i,
    output logic       any_exc_o,
    output logic [4:0] exc_code_o,
    output logic       bad_addr_valid_o,
    output logic       bad_addr_sel_o
);

    exc_flags_t flags;
    assign flags = exc_flags_t'(flags_i);

    always_comb begin
        any_exc_o        = 1'b1;
        exc_code_o       = EXC_INT;
        bad_addr_valid_o = 1'b0;
        bad_addr_sel_o   = BAD_ADDR_PC;
        if (int_req_i) begin
            exc_code_o = EXC_INT;
        end else if (flags.if_adel) begin
            // Fetch address error: the faulting address is the PC itself.
            exc_code_o       = EXC_ADEL;
            bad_addr_valid_o = 1'b1;
            bad_addr_sel_o   = BAD_ADDR_PC;
        end else if (flags.ri) begin
            exc_code_o = EXC_RI;
        end else if (flags.syscall) begin
            exc_code_o = EXC_SYS;
        end else if (flags.brk) begin
            exc_code_o = EXC_BP;
        end else if (flags.ov) begin
            exc_code_o = EXC_OV;
        end else if (flags.adel) begin
            exc_code_o       = EXC_ADEL;
            bad_addr_valid_o = 1'b1;
            bad_addr_sel_o   = BAD_ADDR_DATA;
        end else if (flags.ades) begin
            exc_code_o       = EXC_ADES;
            bad_addr_valid_o = 1'b1;
            bad_addr_sel_o   = BAD_ADDR_DATA;
        end else begin
            any_exc_o = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_unit.sv
// -----------------------------------------------------------------------------
// exc_commit_unit
// Commit-stage initiator of the CP0 exception interface. Prioritises
// interrupts, instruction exceptions and ERET for the M-stage instruction,
// strobes CP0 for one cycle with the payload, kills and flushes, then holds a
// PC redirect until fetch acknowledges it and the minimum flush has elapsed.
// Ports:
//   clk, resetn                     - clock, synchronous active-low reset
//   m_valid, m_stall                - M instruction present / held by data bus
//   m_pc, m_in_delay_slot           - M instruction PC and delay-slot bit
//   m_flags                         - exc_flags_t of the M instruction
//   m_data_addr                     - load/store effective address
//   cp0_interrupt, cp0_epc          - CP0 interrupt request and current EPC
//   redirect_ack                    - fetch accepted redirect_pc
//   cp0_exception, cp0_eret         - one-cycle event strobes to CP0
//   cp0_exc_code, cp0_bad_addr_valid, cp0_bad_vaddr,
//   cp0_exc_pc, cp0_in_delay_slot   - exception payload to CP0
//   commit_kill                     - suppress M-stage writes
//   flush_out                       - flush IF/ID/EX and M->W
//   redirect_valid, redirect_pc     - redirect request to fetch
// -----------------------------------------------------------------------------
module exc_commit_unit
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR       = 32'hBFC0_0380,
    parameter int          MIN_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic        m_stall,
    input  logic [31:0] m_pc,
    input  logic        m_in_delay_slot,
    input  logic [7:0]  m_flags,
    input  logic [31:0] m_data_addr,
    input  logic        cp0_interrupt,
    input  logic [31:0] cp0_epc,
    input  logic        redirect_ack,
    output logic        cp0_exception,
    output logic [5:0]  cp0_exc_code,
    output logic        cp0_bad_addr_valid,
    output logic [31:0] cp0_bad_vaddr,
    output logic [31:0] cp0_exc_pc,
    output logic        cp0_in_delay_slot,
    output logic        cp0_eret,
    output logic        commit_kill,
    output logic        flush_out,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [3:0] FLUSH_INIT = 4'(MIN_FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic        int_pending_q, int_pending_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        ack_seen_q, ack_seen_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    exc_flags_t  flags;
    logic        commit;
    logic        int_req;
    logic        any_exc;
    logic [4:0]  enc_code;
    logic        enc_bad_valid;
    logic        enc_bad_sel;
    logic        exc_event;
    logic        eret_event;

    assign flags   = exc_flags_t'(m_flags);
    assign commit  = (state_q == IDLE) && m_valid && !m_stall;
    assign int_req = cp0_interrupt || int_pending_q;

    exc_prio_enc u_prio (
        .flags_i         (m_flags),
        .int_req_i       (int_req),
        .any_exc_o       (any_exc),
        .exc_code_o      (enc_code),
        .bad_addr_valid_o(enc_bad_valid),
        .bad_addr_sel_o  (enc_bad_sel)
    );

    assign exc_event  = commit && any_exc;
    assign eret_event = commit && !any_exc && flags.eret;

    // Remember an interrupt that arrived while nothing could commit, so it is
    // taken on the next committing instruction; drop it if the request falls.
    assign int_pending_d = cp0_interrupt && (int_pending_q || !commit);

    assign redirect_pc = redirect_pc_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            int_pending_q <= 1'b0;
            flush_cnt_q   <= 4'd0;
            ack_seen_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            int_pending_q <= int_pending_d;
            flush_cnt_q   <= flush_cnt_d;
            ack_seen_q    <= ack_seen_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        flush_cnt_d        = flush_cnt_q;
        ack_seen_d         = ack_seen_q;
        redirect_pc_d      = redirect_pc_q;
        cp0_exception      = 1'b0;
        cp0_eret           = 1'b0;
        cp0_exc_code       = 6'd0;
        cp0_bad_addr_valid = 1'b0;
        cp0_bad_vaddr      = 32'd0;
        cp0_exc_pc         = 32'd0;
        cp0_in_delay_slot  = 1'b0;
        commit_kill        = 1'b0;
        flush_out          = 1'b0;
        redirect_valid     = 1'b0;

        if (state_q == IDLE) begin
            if (exc_event || eret_event) begin
                cp0_exception     = exc_event;
                cp0_eret          = eret_event;
                cp0_exc_pc        = m_pc;
                cp0_in_delay_slot = m_in_delay_slot;
                commit_kill       = 1'b1;
                flush_out         = 1'b1;
                if (exc_event) begin
                    cp0_exc_code       = {1'b0, enc_code};
                    cp0_bad_addr_valid = enc_bad_valid;
                    if (enc_bad_valid) begin
                        cp0_bad_vaddr = (enc_bad_sel == BAD_ADDR_DATA) ? m_data_addr : m_pc;
                    end
                end
                state_d       = REDIRECT;
                flush_cnt_d   = FLUSH_INIT;
                ack_seen_d    = 1'b0;
                redirect_pc_d = exc_event ? EXC_VECTOR : cp0_epc;
            end
        end else begin
            // Whatever sits in M now is wrong-path: kill it, ignore its flags.
            redirect_valid = 1'b1;
            flush_out      = 1'b1;
            commit_kill    = 1'b1;
            if (flush_cnt_q != 4'd0) begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
            if (redirect_ack) begin
                ack_seen_d = 1'b1;
            end
            // An early ack is held in ack_seen until the minimum flush is done.
            if ((redirect_ack || ack_seen_q) && (flush_cnt_q == 4'd0)) begin
                state_d = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_exc_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_exc_commit_unit
// Directed scenarios with fixed expected values, then randomized traffic
// compared every cycle against a cause-list / event-age reference model.
// -----------------------------------------------------------------------------
module tb_exc_commit_unit;

    localparam logic [31:0] VEC      = 32'hBFC0_0380;
    localparam int          MIN_FL   = 2;
    localparam int          N_RANDOM = 3000;

    logic        clk;
    logic        resetn;
    logic        m_valid;
    logic        m_stall;
    logic [31:0] m_pc;
    logic        m_in_delay_slot;
    logic [7:0]  m_flags;
    logic [31:0] m_data_addr;
    logic        cp0_interrupt;
    logic [31:0] cp0_epc;
    logic        redirect_ack;
    logic        cp0_exception;
    logic [5:0]  cp0_exc_code;
    logic        cp0_bad_addr_valid;
    logic [31:0] cp0_bad_vaddr;
    logic [31:0] cp0_exc_pc;
    logic        cp0_in_delay_slot;
    logic        cp0_eret;
    logic        commit_kill;
    logic        flush_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    exc_commit_unit #(
        .EXC_VECTOR      (VEC),
        .MIN_FLUSH_CYCLES(MIN_FL)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .m_valid           (m_valid),
        .m_stall           (m_stall),
        .m_pc              (m_pc),
        .m_in_delay_slot   (m_in_delay_slot),
        .m_flags           (m_flags),
        .m_data_addr       (m_data_addr),
        .cp0_interrupt     (cp0_interrupt),
        .cp0_epc           (cp0_epc),
        .redirect_ack      (redirect_ack),
        .cp0_exception     (cp0_exception),
        .cp0_exc_code      (cp0_exc_code),
        .cp0_bad_addr_valid(cp0_bad_addr_valid),
        .cp0_bad_vaddr     (cp0_bad_vaddr),
        .cp0_exc_pc        (cp0_exc_pc),
        .cp0_in_delay_slot (cp0_in_delay_slot),
        .cp0_eret          (cp0_eret),
        .commit_kill       (commit_kill),
        .flush_out         (flush_out),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Causes are ranked by a table indexed by flag bit;
    // the redirect phase is tracked as "cycles since the event".
    // ------------------------------------------------------------------
    int code_of_bit [8] = '{0, 5, 4, 12, 9, 8, 10, 4};

    bit          md_redir;
    int          md_age;
    bit          md_acked;
    bit          md_irq_wait;
    logic [31:0] md_rpc;
    bit          ev_exc, ev_eret;

    logic        e_exc, e_eret, e_bav, e_ids, e_kill, e_flush, e_rv;
    logic [5:0]  e_code;
    logic [31:0] e_bva, e_epc, e_rpc;

    task automatic model_reset();
        md_redir    = 0;
        md_age      = 0;
        md_acked    = 0;
        md_irq_wait = 0;
        md_rpc      = 32'd0;
    endtask

    task automatic model_eval();
        bit commit;
        int cause;
        e_exc = 0; e_eret = 0; e_bav = 0; e_ids = 0; e_kill = 0; e_flush = 0; e_rv = 0;
        e_code = 0; e_bva = 0; e_epc = 0; e_rpc = md_rpc;
        ev_exc = 0; ev_eret = 0;
        if (md_redir) begin
            e_kill = 1; e_flush = 1; e_rv = 1;
        end else begin
            commit = m_valid && !m_stall;
            cause  = -1;
            if (commit) begin
                if (cp0_interrupt || md_irq_wait) cause = 8;
                else
                    for (int b = 7; b >= 1; b--)
                        if (cause < 0 && m_flags[b]) cause = b;
                if (cause >= 0) begin
                    ev_exc = 1;
                    e_exc  = 1;
                    e_code = (cause == 8) ? 6'd0 : 6'(code_of_bit[cause]);
                    if (cause == 7) begin
                        e_bav = 1; e_bva = m_pc;
                    end else if (cause == 1 || cause == 2) begin
                        e_bav = 1; e_bva = m_data_addr;
                    end
                end else if (m_flags[0]) begin
                    ev_eret = 1;
                    e_eret  = 1;
                end
                if (ev_exc || ev_eret) begin
                    e_epc = m_pc; e_ids = m_in_delay_slot; e_kill = 1; e_flush = 1;
                end
            end
        end
    endtask

    task automatic model_step();
        bit commit;
        if (!resetn) begin
            model_reset();
        end else if (md_redir) begin
            md_irq_wait = cp0_interrupt;
            if (redirect_ack) md_acked = 1;
            if (md_age >= MIN_FL - 1 && md_acked) md_redir = 0;
            else md_age++;
        end else begin
            commit = m_valid && !m_stall;
            // A request seen while nothing commits waits; a commit takes it.
            md_irq_wait = cp0_interrupt && !commit;
            if (ev_exc || ev_eret) begin
                md_redir = 1;
                md_age   = 0;
                md_acked = 0;
                md_rpc   = ev_exc ? VEC : cp0_epc;
            end
        end
    endtask

    task automatic check_model();
        chk("exception", 32'(cp0_exception), 32'(e_exc));
        chk("eret", 32'(cp0_eret), 32'(e_eret));
        chk("exc_code", 32'(cp0_exc_code), 32'(e_code));
        chk("bad_addr_valid", 32'(cp0_bad_addr_valid), 32'(e_bav));
        chk("bad_vaddr", cp0_bad_vaddr, e_bva);
        chk("exc_pc", cp0_exc_pc, e_epc);
        chk("in_delay_slot", 32'(cp0_in_delay_slot), 32'(e_ids));
        chk("commit_kill", 32'(commit_kill), 32'(e_kill));
        chk("flush_out", 32'(flush_out), 32'(e_flush));
        chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        chk("redirect_pc", redirect_pc, e_rpc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_exception"}, 32'(cp0_exception), 0);
        chk({tag, "_eret"}, 32'(cp0_eret), 0);
        chk({tag, "_exc_code"}, 32'(cp0_exc_code), 0);
        chk({tag, "_bad_addr_valid"}, 32'(cp0_bad_addr_valid), 0);
        chk({tag, "_bad_vaddr"}, cp0_bad_vaddr, 0);
        chk({tag, "_exc_pc"}, cp0_exc_pc, 0);
        chk({tag, "_in_delay_slot"}, 32'(cp0_in_delay_slot), 0);
        chk({tag, "_commit_kill"}, 32'(commit_kill), 0);
        chk({tag, "_flush_out"}, 32'(flush_out), 0);
        chk({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
        chk({tag, "_redirect_pc"}, redirect_pc, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_valid = 0; m_stall = 0; m_pc = 0; m_in_delay_slot = 0; m_flags = 0;
        m_data_addr = 0; cp0_epc = 0;
    endtask

    // Ends at a negedge with the DUT idle, or records a failure after a bound.
    task automatic wait_idle(input string tag);
        bit idle = 0;
        clear_inputs();
        redirect_ack = 1;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (!redirect_valid) idle = 1;
            else tick();
        end
        if (!idle) chk({tag, "_idle_timeout"}, 32'(redirect_valid), 0);
    endtask

    initial begin
        int flush_cnt;
        resetn = 0;
        cp0_interrupt = 0;
        redirect_ack = 0;
        clear_inputs();
        tick();
        tick();
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        resetn = 1;

        // Overflow with ack tied high: event payload, vector, 3-cycle flush.
        redirect_ack = 1;
        m_valid = 1; m_flags = 8'h08; m_pc = 32'h8000_0100;
        @(negedge clk);
        chk("ov_exception", 32'(cp0_exception), 1);
        chk("ov_code", 32'(cp0_exc_code), 32'h0C);
        chk("ov_exc_pc", cp0_exc_pc, 32'h8000_0100);
        chk("ov_kill", 32'(commit_kill), 1);
        chk("ov_bad_valid", 32'(cp0_bad_addr_valid), 0);
        flush_cnt = flush_out ? 1 : 0;
        tick();
        clear_inputs();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("ov_redirect_pc", redirect_pc, VEC);
            if (k == 0) chk("ov_strobe_once", 32'(cp0_exception), 0);
            if (flush_out) flush_cnt++;
            tick();
        end
        chk("ov_flush_len", 32'(flush_cnt), 3);

        // Store address error in a delay slot.
        wait_idle("ades");
        tick();
        m_valid = 1; m_flags = 8'h02; m_pc = 32'h8000_0104;
        m_data_addr = 32'h8000_0003; m_in_delay_slot = 1;
        @(negedge clk);
        chk("ades_code", 32'(cp0_exc_code), 32'h05);
        chk("ades_bad_valid", 32'(cp0_bad_addr_valid), 1);
        chk("ades_bad_vaddr", cp0_bad_vaddr, 32'h8000_0003);
        chk("ades_delay_slot", 32'(cp0_in_delay_slot), 1);

        // Fetch error beats reserved instruction.
        wait_idle("ifadel");
        tick();
        m_valid = 1; m_flags = 8'hC0; m_pc = 32'h8000_0001; m_data_addr = 32'h1234_5678;
        @(negedge clk);
        chk("ifadel_code", 32'(cp0_exc_code), 32'h04);
        chk("ifadel_bad_vaddr", cp0_bad_vaddr, 32'h8000_0001);

        // Interrupt arriving over bubbles is taken on the next clean instruction.
        wait_idle("int");
        tick();
        cp0_interrupt = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("int_bubble_no_strobe", 32'(cp0_exception), 0);
            tick();
        end
        m_valid = 1; m_pc = 32'h8000_0040;
        @(negedge clk);
        chk("int_exception", 32'(cp0_exception), 1);
        chk("int_code", 32'(cp0_exc_code), 32'h00);
        chk("int_exc_pc", cp0_exc_pc, 32'h8000_0040);
        tick();
        cp0_interrupt = 0;

        // ERET redirects to EPC.
        wait_idle("eret");
        tick();
        m_valid = 1; m_flags = 8'h01; m_pc = 32'h8000_0300; cp0_epc = 32'h8000_0200;
        @(negedge clk);
        chk("eret_strobe", 32'(cp0_eret), 1);
        chk("eret_no_exc", 32'(cp0_exception), 0);
        tick();
        clear_inputs();
        @(negedge clk);
        chk("eret_one_cycle", 32'(cp0_eret), 0);
        chk("eret_redirect_pc", redirect_pc, 32'h8000_0200);
        chk("eret_redirect_valid", 32'(redirect_valid), 1);

        // Reset while a redirect waits for an ack.
        wait_idle("rst");
        tick();
        redirect_ack = 0;
        m_valid = 1; m_flags = 8'h10; m_pc = 32'h8000_0500;
        @(negedge clk);
        chk("rst_event", 32'(cp0_exception), 1);
        tick();
        clear_inputs();
        tick();
        resetn = 0;
        tick();
        resetn = 1;
        @(negedge clk);
        chk_all_zero("rst_mid_redirect");

        // Randomized traffic against the reference model.
        model_reset();
        for (int c = 0; c < N_RANDOM; c++) begin
            tick();
            resetn          = ($urandom_range(0, 199) != 0);
            m_valid         = ($urandom_range(0, 3) != 0);
            m_stall         = ($urandom_range(0, 4) == 0);
            m_pc            = $urandom;
            m_in_delay_slot = 1'($urandom);
            m_data_addr     = $urandom;
            cp0_epc         = $urandom;
            redirect_ack    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) cp0_interrupt = ~cp0_interrupt;
            if ($urandom_range(0, 2) == 0) begin
                m_flags = 8'(1 << $urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) m_flags = m_flags | 8'($urandom);
            end else begin
                m_flags = 8'h00;
            end
            model_eval();
            @(negedge clk);
            check_model();
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
